// File: rtl/pattern_sequencer_if.sv
// Bundles the frame-advance controls and the pattern/transition outputs
// of the pattern sequencer.
// The master drives the controls (speed controller, bench); the slave is
// the sequencer itself.
interface pattern_sequencer_if #(
    parameter int SEL_W   = 2,
    parameter int FRAME_W = 8
);
    logic               next_frame;
    logic               advance;
    logic [1:0]         mode;
    logic [SEL_W-1:0]   pattern_select;
    logic [SEL_W-1:0]   pattern_upcoming;
    logic [FRAME_W-1:0] frame_count;
    logic               in_transition;
    logic [FRAME_W-1:0] blend_step;
    logic               pattern_changed;

    modport master (
        output next_frame,
        output advance,
        output mode,
        input  pattern_select,
        input  pattern_upcoming,
        input  frame_count,
        input  in_transition,
        input  blend_step,
        input  pattern_changed
    );

    modport slave (
        input  next_frame,
        input  advance,
        input  mode,
        output pattern_select,
        output pattern_upcoming,
        output frame_count,
        output in_transition,
        output blend_step,
        output pattern_changed
    );
endinterface

// File: rtl/pattern_sequencer.sv
// Background pattern sequencer for the VGA demoscene top level.
// Steps through NUM_PATTERNS patterns in cycle, reverse, ping-pong or hold
// order on next_frame pulses, with a manual skip, and exposes a transition
// window at the tail of each pattern so a blender can dissolve into the
// upcoming pattern.
module pattern_sequencer #(
    parameter int NUM_PATTERNS       = 4,
    parameter int SEL_W              = 2,
    parameter int FRAME_W            = 8,
    parameter int FRAMES_PER_PATTERN = 240,
    parameter int TRANS_FRAMES       = 16
) (
    input logic                clk,
    input logic                rst,
    pattern_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_CYCLE    = 2'd0,
        MODE_REVERSE  = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_HOLD     = 2'd3
    } mode_e;

    localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_PATTERNS - 1);
    localparam logic [SEL_W-1:0]   SEL_ONE    = SEL_W'(1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_PATTERN - 1);
    localparam logic [FRAME_W-1:0] WIN_START  = FRAME_W'(FRAMES_PER_PATTERN - TRANS_FRAMES);
    localparam bit                 HAS_WINDOW = (TRANS_FRAMES != 0);

    mode_e              mode;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   next_sel;
    logic               dir;
    logic               next_dir;
    logic [FRAME_W-1:0] frame_count;
    logic               pattern_changed;
    logic               in_window;

    assign mode = mode_e'(bus.mode);

    // Next-index rule for the current mode; HOLD borrows the CYCLE rule so a
    // manual skip still moves forward. dir is only rewritten by ping-pong.
    always_comb begin
        next_sel = '0;
        next_dir = dir;
        if (sel > SEL_LAST) begin
            next_sel = '0;
        end else begin
            case (mode)
                MODE_REVERSE: begin
                    next_sel = (sel == '0) ? SEL_LAST : sel - SEL_ONE;
                end
                MODE_PINGPONG: begin
                    if (!dir) begin
                        if (sel == SEL_LAST) begin
                            next_sel = sel - SEL_ONE;
                            next_dir = 1'b1;
                        end else begin
                            next_sel = sel + SEL_ONE;
                        end
                    end else begin
                        if (sel == '0) begin
                            next_sel = SEL_ONE;
                            next_dir = 1'b0;
                        end else begin
                            next_sel = sel - SEL_ONE;
                        end
                    end
                end
                default: begin
                    next_sel = (sel == SEL_LAST) ? '0 : sel + SEL_ONE;
                end
            endcase
        end
    end

    // Frame counting and pattern switching; a manual skip wins over a
    // coincident frame pulse, and HOLD lets the counter wrap without switching.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel             <= '0;
            dir             <= 1'b0;
            frame_count     <= '0;
            pattern_changed <= 1'b0;
        end else begin
            pattern_changed <= 1'b0;
            if (bus.advance) begin
                sel             <= next_sel;
                dir             <= next_dir;
                frame_count     <= '0;
                pattern_changed <= 1'b1;
            end else if (bus.next_frame) begin
                if (frame_count >= FRAME_LAST) begin
                    frame_count <= '0;
                    if (mode != MODE_HOLD) begin
                        sel             <= next_sel;
                        dir             <= next_dir;
                        pattern_changed <= 1'b1;
                    end
                end else begin
                    frame_count <= frame_count + FRAME_W'(1);
                end
            end
        end
    end

    assign in_window = HAS_WINDOW && (mode != MODE_HOLD) && (frame_count >= WIN_START);

    assign bus.pattern_select   = sel;
    assign bus.pattern_upcoming = next_sel;
    assign bus.frame_count      = frame_count;
    assign bus.in_transition    = in_window;
    assign bus.blend_step       = in_window ? (frame_count - WIN_START) : '0;
    assign bus.pattern_changed  = pattern_changed;

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Parametrised pattern sequencer driving the background pattern index for the VGA demoscene top level. It generalises the fixed two-pattern alternation to NUM_PATTERNS patterns with cycle, reverse, ping-pong and hold modes, and a manual skip input. It also exposes a transition window (frame counter, upcoming pattern, blend step) so a downstream blender can dissolve between patterns. It advances only on the speed controller's next_frame pulse, so pause and speed apply to it unchanged.

## Interface
Parameters:
- NUM_PATTERNS, 4, number of patterns; legal 2..16
- SEL_W, 2, pattern index width; must be at least $clog2(NUM_PATTERNS)
- FRAME_W, 8, frame counter width
- FRAMES_PER_PATTERN, 240, frames each pattern is shown; legal 2..2^FRAME_W-1
- TRANS_FRAMES, 16, length of the transition window at the end of each pattern; legal 0..FRAMES_PER_PATTERN-1

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; asynchronous, active-high
- next_frame  in  1  single-cycle frame-advance pulse from the speed controller
- advance  in  1  single-cycle manual skip pulse
- mode  in  2  0=CYCLE, 1=REVERSE, 2=PINGPONG, 3=HOLD
- pattern_select  out  SEL_W  current pattern index (registered)
- pattern_upcoming  out  SEL_W  index that the next switch will select (combinational from registered state and mode)
- frame_count  out  FRAME_W  frames shown of the current pattern (registered)
- in_transition  out  1  high while frame_count is inside the transition window
- blend_step  out  FRAME_W  position within the transition window; 0 outside it
- pattern_changed  out  1  one-cycle pulse after every switch (registered)

## Operation
- State: sel, frame_count, dir (0=up, 1=down), pattern_changed.
- next_frame without advance:
  - If frame_count < FRAMES_PER_PATTERN-1: frame_count increments.
  - Otherwise frame_count becomes 0 and, if mode != HOLD, sel takes the next-index value and pattern_changed pulses.
  - In HOLD, frame_count still wraps but sel does not change and pattern_changed does not pulse.
- advance (any mode, regardless of next_frame): sel takes the next-index value, frame_count becomes 0, pattern_changed pulses. A coincident next_frame is discarded.
  - HOLD uses the CYCLE rule for advance.
- Next-index rules:
  - CYCLE: sel == NUM_PATTERNS-1 ? 0 : sel+1.
  - REVERSE: sel == 0 ? NUM_PATTERNS-1 : sel-1.
  - PINGPONG: move one step in direction dir. At an end, dir flips and the move goes the other way: up at NUM_PATTERNS-1 moves to NUM_PATTERNS-2 with dir=down; down at 0 moves to 1 with dir=up. Ends are not repeated. dir updates only on a PINGPONG switch.
- pattern_upcoming always applies the rule for the current mode input (HOLD shows the CYCLE rule).
- Mode changes take effect at the next switch. No state is reset on a mode change; dir is retained.
- in_transition = (mode != HOLD) && TRANS_FRAMES != 0 && frame_count >= FRAMES_PER_PATTERN-TRANS_FRAMES.
- blend_step = in_transition ? frame_count - (FRAMES_PER_PATTERN-TRANS_FRAMES) : 0. Range 0..TRANS_FRAMES-1, unsigned, no overflow.
- sel never leaves 0..NUM_PATTERNS-1. An out-of-range sel (e.g. SEL_W wider than needed) is forced to 0 on the next switch.

## Timing
- Reset values: sel=0, frame_count=0, dir=up, pattern_changed=0, in_transition=0, blend_step=0. pattern_upcoming after reset is 1 in CYCLE/PINGPONG/HOLD and NUM_PATTERNS-1 in REVERSE.
- Reset is asynchronous: all registers clear immediately, including mid-transition, and the outputs above are valid while rst is high.
- Latency: a next_frame or advance sampled at edge N updates sel and frame_count at edge N. pattern_changed is high from edge N to edge N+1.
- in_transition and blend_step are combinational from frame_count and mode: zero extra latency, not registered.
- Back-to-back pulses are legal; every cycle's next_frame/advance is honoured.

## Test plan
Bench parameters: NUM_PATTERNS=3, FRAMES_PER_PATTERN=4, TRANS_FRAMES=2.
- CYCLE, 12 next_frame pulses → sel 0,0,0,0,1,1,1,1,2,2,2,2 then 0. Three pattern_changed pulses, each exactly one cycle wide.
- CYCLE, frame_count stepping 0..3 → in_transition low at counts 0 and 1, high at 2 and 3. blend_step reads 0,0,0,1.
- PINGPONG, 6 switches from reset → sel 1,2,1,0,1,2. REVERSE from sel=0 → 2,1,0.
- HOLD, 8 next_frame pulses → sel stays 0, frame_count wraps 3→0, no pattern_changed, in_transition stays 0. advance in HOLD → sel=1, frame_count=0.
- advance and next_frame in the same cycle at frame_count=2 → sel+1, frame_count=0, one pattern_changed pulse.
- rst asserted mid-window (frame_count=3, sel=2, PINGPONG with dir=down) → all outputs at reset values before the next clk edge. The first switch after reset goes 0→1.
